// File: rtl/parity_rr_scheduler.sv
// Round-robin arbiter feeding one serial parity lane; each granted word is shifted out LSB-first and judged.
// Latency: bits on lane at grant edge E0..E(DATA_W-1), verdict at E(DATA_W); no backpressure, requests wait in IDLE.
module parity_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_mode,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      ser_valid,
    output logic                      ser_data,
    output logic                      ser_mode,
    output logic                      busy,
    output logic                      done,
    output logic [ID_W-1:0]           done_id,
    output logic                      done_ok
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t              state, state_nxt;
    logic [ID_W-1:0]     ptr, ptr_nxt;
    logic [ID_W-1:0]     id, id_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                acc, acc_nxt;
    logic [DATA_W-1:0]   shreg, shreg_nxt;

    logic [NUM_REQ-1:0]  gnt_nxt;
    logic                ser_valid_nxt;
    logic                ser_data_nxt;
    logic                ser_mode_nxt;
    logic                busy_nxt;
    logic                done_nxt;
    logic [ID_W-1:0]     done_id_nxt;
    logic                done_ok_nxt;

    logic                found;
    logic [ID_W-1:0]     sel;
    logic [ID_W:0]       idx;
    logic [DATA_W-1:0]   word;
    logic                mode;

    // Scan from the pointer upward, wrapping, and take the first requester.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr} + (ID_W + 1)'(k);
            if (idx >= (ID_W + 1)'(NUM_REQ)) begin
                idx = idx - (ID_W + 1)'(NUM_REQ);
            end
            if (!found && req[idx[ID_W-1:0]]) begin
                found = 1'b1;
                sel   = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel == ID_W'(i)) begin
                word = req_data[i*DATA_W +: DATA_W];
            end
        end
        mode = req_mode[sel];
    end

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        id_nxt        = id;
        cnt_nxt       = cnt;
        acc_nxt       = acc;
        shreg_nxt     = shreg;
        gnt_nxt       = '0;
        ser_valid_nxt = ser_valid;
        ser_data_nxt  = ser_data;
        ser_mode_nxt  = ser_mode;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        done_id_nxt   = done_id;
        done_ok_nxt   = done_ok;

        case (state)
            IDLE: begin
                if (found) begin
                    gnt_nxt       = NUM_REQ'(1) << sel;
                    id_nxt        = sel;
                    shreg_nxt     = word >> 1;
                    ser_valid_nxt = 1'b1;
                    ser_data_nxt  = word[0];
                    ser_mode_nxt  = mode;
                    busy_nxt      = 1'b1;
                    cnt_nxt       = CNT_W'(1);
                    acc_nxt       = word[0];
                    ptr_nxt       = (sel == ID_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
                    state_nxt     = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CNT_W'(DATA_W)) begin
                    ser_valid_nxt = 1'b0;
                    ser_data_nxt  = 1'b0;
                    ser_mode_nxt  = 1'b0;
                    busy_nxt      = 1'b0;
                    done_nxt      = 1'b1;
                    done_id_nxt   = id;
                    // ser_mode still carries the mode latched at the grant edge here.
                    done_ok_nxt   = (acc == ser_mode);
                    cnt_nxt       = '0;
                    acc_nxt       = 1'b0;
                    state_nxt     = IDLE;
                end else begin
                    ser_data_nxt  = shreg[0];
                    acc_nxt       = acc ^ shreg[0];
                    shreg_nxt     = shreg >> 1;
                    cnt_nxt       = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            id        <= '0;
            cnt       <= '0;
            acc       <= 1'b0;
            shreg     <= '0;
            gnt       <= '0;
            ser_valid <= 1'b0;
            ser_data  <= 1'b0;
            ser_mode  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            done_id   <= '0;
            done_ok   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            id        <= id_nxt;
            cnt       <= cnt_nxt;
            acc       <= acc_nxt;
            shreg     <= shreg_nxt;
            gnt       <= gnt_nxt;
            ser_valid <= ser_valid_nxt;
            ser_data  <= ser_data_nxt;
            ser_mode  <= ser_mode_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            done_id   <= done_id_nxt;
            done_ok   <= done_ok_nxt;
        end
    end

endmodule

// File: tb/tb_parity_rr_scheduler.sv
// Directed bench for parity_rr_scheduler: table of single frames plus arbitration and reset sequences.
module tb_parity_rr_scheduler;
    localparam int NR = 4;
    localparam int DW = 8;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_mode;
    logic [NR-1:0]     gnt;
    logic              ser_valid, ser_data, ser_mode, busy, done, done_ok;
    logic [IW-1:0]     done_id;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int         idx;
        logic [7:0] data;
        logic       mode;
        logic       exp_ok;
        logic       clobber;
    } vec_t;

    vec_t vecs[7];

    parity_rr_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .ID_W(IW)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_mode(req_mode),
        .gnt(gnt), .ser_valid(ser_valid), .ser_data(ser_data), .ser_mode(ser_mode),
        .busy(busy), .done(done), .done_id(done_id), .done_ok(done_ok)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Waits (bounded) for the next grant; exp_wait is the number of clock edges it should take.
    task automatic expect_gnt(input string name, input logic [NR-1:0] exp, input int exp_wait);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt == '0 && n < 40);
        chk({name, "_gnt"}, gnt, exp);
        chk({name, "_wait"}, n, exp_wait);
    endtask

    task automatic run_frame(input vec_t v, input int num);
        string tag;
        tag = $sformatf("vec%0d", num);
        req_data = $urandom;
        req_data[v.idx*DW +: DW] = v.data;
        req_mode = 4'($urandom);
        req_mode[v.idx] = v.mode;
        req = '0;
        req[v.idx] = 1'b1;
        @(negedge clk);
        req = '0;
        chk({tag, "_gnt"}, gnt, 32'(1) << v.idx);
        chk({tag, "_bit0"}, ser_data, v.data[0]);
        chk({tag, "_valid0"}, ser_valid, 1);
        chk({tag, "_busy0"}, busy, 1);
        chk({tag, "_mode0"}, ser_mode, v.mode);
        for (int b = 1; b < DW; b++) begin
            if (v.clobber && b == 3) begin
                req_data[v.idx*DW +: DW] = '0;
                req_mode[v.idx] = ~v.mode;
            end
            @(negedge clk);
            chk($sformatf("%s_bit%0d", tag, b), ser_data, v.data[b]);
            chk($sformatf("%s_valid%0d", tag, b), ser_valid, 1);
            chk($sformatf("%s_smode%0d", tag, b), ser_mode, v.mode);
            if (b == 1) chk({tag, "_gnt_drop"}, gnt, 0);
        end
        @(negedge clk);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_done_id"}, done_id, v.idx);
        chk({tag, "_done_ok"}, done_ok, v.exp_ok);
        chk({tag, "_valid_end"}, ser_valid, 0);
        chk({tag, "_busy_end"}, busy, 0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_ok_hold"}, done_ok, v.exp_ok);
    endtask

    initial begin
        int dones;
        vecs[0] = '{0, 8'hA5, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{2, 8'h07, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{2, 8'h07, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{1, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{3, 8'hFF, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1, 8'h80, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{0, 8'h5B, 1'b1, 1'b1, 1'b1};

        reset    = 1'b1;
        req      = '0;
        req_data = '0;
        req_mode = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_gnt", gnt, 0);
        chk("rst_valid", ser_valid, 0);
        chk("rst_data", ser_data, 0);
        chk("rst_mode", ser_mode, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_done_id", done_id, 0);
        chk("rst_done_ok", done_ok, 0);

        for (int i = 0; i < 7; i++) run_frame(vecs[i], i);

        // All four requesting continuously: strict rotation, one grant per DW+1 cycles.
        do_reset();
        req_data = 32'h0403_0201;
        req_mode = 4'b0000;
        req = 4'b1111;
        expect_gnt("rr0", 4'b0001, 1);
        expect_gnt("rr1", 4'b0010, 9);
        chk("rr1_done_id", done_id, 0);
        expect_gnt("rr2", 4'b0100, 9);
        chk("rr2_done_id", done_id, 1);
        expect_gnt("rr3", 4'b1000, 9);
        chk("rr3_done_id", done_id, 2);
        expect_gnt("rr4", 4'b0001, 9);
        chk("rr4_done_id", done_id, 3);
        req = '0;
        repeat (10) @(negedge clk);

        // Pointer-driven selection with sparse request patterns.
        do_reset();
        req = 4'b0001;
        expect_gnt("ptr_a", 4'b0001, 1);
        req = 4'b1010;
        expect_gnt("ptr_b", 4'b0010, 9);
        req = 4'b1000;
        expect_gnt("ptr_c", 4'b1000, 9);
        req = 4'b0001;
        expect_gnt("ptr_d", 4'b0001, 9);
        req = 4'b0101;
        expect_gnt("ptr_e", 4'b0100, 9);
        req = 4'b0001;
        expect_gnt("ptr_f", 4'b0001, 9);
        req = '0;
        repeat (10) @(negedge clk);

        // Reset while bit 4 is on the lane: abort, no done, pointer back to 0.
        do_reset();
        req_data = 32'hFFFF_FFFF;
        req = 4'b0100;
        expect_gnt("abort_gnt", 4'b0100, 1);
        req = '0;
        repeat (4) @(negedge clk);
        chk("abort_busy_pre", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_valid", ser_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_data", ser_data, 0);
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            if (done) dones++;
            @(negedge clk);
        end
        chk("abort_no_done", dones, 0);
        req = 4'b1001;
        expect_gnt("abort_regnt", 4'b0001, 1);
        req = '0;
        repeat (8) @(negedge clk);
        chk("abort_after_done", done, 1);
        chk("abort_after_id", done_id, 0);
        chk("abort_after_ok", done_ok, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
